match_filter_ctrl: RTL and testbench

Sequencing and configuration controller for the receive-path match filter. It holds a host-writable shadow bank of eight 32-bit words: the threshold/length word plus coefficient words. On commit it waits for the filter pipeline to drain, then replays the bank into the filter's `cwrite`/`cstate`/`cdata` port. While it waits and loads, it withholds receive strobes so that coefficient writes never collide with an in-flight correlation. It also qualifies the filter's `valid`/`match` outputs into rate-limited match events and saturating counters for the in-band status path.

---
 rtl/match_filter_ctrl.sv | 129 ++++++++++++
 tb/tb_match_filter_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/match_filter_ctrl.sv
// Configuration sequencer and match qualifier for the receive-path match filter.
// Replays a shadow coefficient bank into the filter once the pipeline is quiet.
module match_filter_ctrl #(
  parameter int PIPE_DEPTH = 12,
  parameter int HOLDOFF    = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_addr,
  input  logic [31:0] cfg_data,
  input  logic        cfg_commit,
  output logic        cfg_reject,
  output logic        busy,
  output logic        load_done,
  input  logic        rxstrobe_in,
  output logic        filt_rxstrobe,
  output logic        cwrite,
  output logic [2:0]  cstate,
  output logic [31:0] cdata,
  input  logic        filt_valid,
  input  logic        filt_match,
  output logic        match_event,
  output logic [15:0] match_count,
  output logic [15:0] drop_count
);

  localparam int QW = $clog2(PIPE_DEPTH + 1);
  localparam int HW = $clog2(HOLDOFF + 1);
  localparam logic [QW-1:0] QMAX = QW'(PIPE_DEPTH);
  localparam logic [HW-1:0] HMAX = HW'(HOLDOFF);

  typedef enum logic [1:0] {IDLE, WAIT_QUIET, LOAD, DONE} state_e;

  state_e        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [QW-1:0] quiet_q, quiet_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [15:0]   match_cnt_q, match_cnt_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;
  logic          reject_q, reject_d;
  logic          event_q, event_d;
  logic [31:0]   shadow_q [8];

  logic is_idle, fwd, drop, match;

  assign is_idle = (state_q == IDLE);
  assign fwd     = rxstrobe_in & is_idle;
  assign drop    = rxstrobe_in & ~is_idle;
  assign match   = filt_valid & filt_match;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      quiet_q     <= QMAX;
      hold_q      <= '0;
      match_cnt_q <= '0;
      drop_cnt_q  <= '0;
      reject_q    <= 1'b0;
      event_q     <= 1'b0;
      for (int i = 0; i < 8; i++) shadow_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      quiet_q     <= quiet_d;
      hold_q      <= hold_d;
      match_cnt_q <= match_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      reject_q    <= reject_d;
      event_q     <= event_d;
      if (is_idle && cfg_we) shadow_q[cfg_addr] <= cfg_data;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cwrite    = 1'b0;
    cstate    = 3'd0;
    cdata     = 32'd0;
    load_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_commit) state_d = WAIT_QUIET;
      end
      WAIT_QUIET: begin
        idx_d = 3'd0;
        if (quiet_q >= QMAX) state_d = LOAD;
      end
      LOAD: begin
        cwrite = 1'b1;
        cstate = idx_q;
        cdata  = shadow_q[idx_q];
        idx_d  = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = DONE;
      end
      DONE: begin
        load_done = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Quiet timer keeps running in every state so the drain check sees all forwarded strobes.
  always_comb begin
    quiet_d     = quiet_q;
    drop_cnt_d  = drop_cnt_q;
    match_cnt_d = match_cnt_q;
    hold_d      = hold_q;
    event_d     = match & (hold_q == '0);
    reject_d    = ~is_idle & (cfg_we | cfg_commit);
    if (fwd) quiet_d = '0;
    else if (quiet_q < QMAX) quiet_d = quiet_q + QW'(1);
    if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    if (match && match_cnt_q != 16'hFFFF) match_cnt_d = match_cnt_q + 16'd1;
    if (event_d) hold_d = HMAX;
    else if (hold_q != '0) hold_d = hold_q - HW'(1);
  end

  assign busy          = ~is_idle;
  assign filt_rxstrobe = fwd;
  assign cfg_reject    = reject_q;
  assign match_event   = event_q;
  assign match_count   = match_cnt_q;
  assign drop_count    = drop_cnt_q;

endmodule

// File: tb/tb_match_filter_ctrl.sv
// Directed, self-checking bench for match_filter_ctrl: load sequencing, strobe
// gating, reject handling, match holdoff, mid-load reset and counter saturation.
module tb_match_filter_ctrl;

  logic        clk;
  logic        reset;
  logic        cfgWe;
  logic [2:0]  cfgAddr;
  logic [31:0] cfgData;
  logic        cfgCommit;
  logic        cfgReject;
  logic        busy;
  logic        loadDone;
  logic        rxStrobe;
  logic        filtRxstrobe;
  logic        cwrite;
  logic [2:0]  cstate;
  logic [31:0] cdata;
  logic        filtValid;
  logic        filtMatch;
  logic        matchEvent;
  logic [15:0] matchCount;
  logic [15:0] dropCount;

  int totalChecks = 0;
  int badChecks   = 0;
  logic [31:0] expShadow [8];

  typedef struct {
    int          gap;
    logic        valid;
    logic        match;
    logic        expEvent;
    logic [15:0] expCount;
  } matchVec_t;

  matchVec_t matchTable [8];

  match_filter_ctrl #(.PIPE_DEPTH(12), .HOLDOFF(64)) dut (
    .clk(clk),
    .reset(reset),
    .cfg_we(cfgWe),
    .cfg_addr(cfgAddr),
    .cfg_data(cfgData),
    .cfg_commit(cfgCommit),
    .cfg_reject(cfgReject),
    .busy(busy),
    .load_done(loadDone),
    .rxstrobe_in(rxStrobe),
    .filt_rxstrobe(filtRxstrobe),
    .cwrite(cwrite),
    .cstate(cstate),
    .cdata(cdata),
    .filt_valid(filtValid),
    .filt_match(filtMatch),
    .match_event(matchEvent),
    .match_count(matchCount),
    .drop_count(dropCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic we, input logic [2:0] addr, input logic [31:0] data,
                               input logic commit, input logic strobe,
                               input logic valid, input logic mtch);
    cfgWe     = we;
    cfgAddr   = addr;
    cfgData   = data;
    cfgCommit = commit;
    rxStrobe  = strobe;
    filtValid = valid;
    filtMatch = mtch;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    totalChecks++;
    if (actual !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Commit from a quiet IDLE cycle and follow the full replay against the shadow model.
  task automatic doCommitLoad(input string tag);
    applyStimulus(1'b0, 3'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 checkOutput({tag, "-idleCwrite"}, cwrite, 0);
    nextCycle();
    applyStimulus(1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput({tag, "-waitBusy"}, busy, 1);
    checkOutput({tag, "-waitCwrite"}, cwrite, 0);
    for (int k = 0; k < 8; k++) begin
      nextCycle();
      checkOutput($sformatf("%s-cwrite%0d", tag, k), cwrite, 1);
      checkOutput($sformatf("%s-cstate%0d", tag, k), cstate, k);
      checkOutput($sformatf("%s-cdata%0d", tag, k), cdata, expShadow[k]);
    end
    nextCycle();
    checkOutput({tag, "-doneLoadDone"}, loadDone, 1);
    checkOutput({tag, "-doneCwrite"}, cwrite, 0);
    checkOutput({tag, "-doneBusy"}, busy, 1);
    nextCycle();
    checkOutput({tag, "-idleBusy"}, busy, 0);
    checkOutput({tag, "-idleLoadDone"}, loadDone, 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rel;
    logic strobe;

    matchTable[0] = '{gap: 0,  valid: 1'b1, match: 1'b1, expEvent: 1'b1, expCount: 16'd1};
    matchTable[1] = '{gap: 9,  valid: 1'b1, match: 1'b1, expEvent: 1'b0, expCount: 16'd2};
    matchTable[2] = '{gap: 5,  valid: 1'b1, match: 1'b0, expEvent: 1'b0, expCount: 16'd2};
    matchTable[3] = '{gap: 53, valid: 1'b1, match: 1'b1, expEvent: 1'b1, expCount: 16'd3};
    matchTable[4] = '{gap: 0,  valid: 1'b0, match: 1'b1, expEvent: 1'b0, expCount: 16'd3};
    matchTable[5] = '{gap: 62, valid: 1'b1, match: 1'b1, expEvent: 1'b0, expCount: 16'd4};
    matchTable[6] = '{gap: 0,  valid: 1'b1, match: 1'b1, expEvent: 1'b1, expCount: 16'd5};
    matchTable[7] = '{gap: 0,  valid: 1'b1, match: 1'b1, expEvent: 1'b0, expCount: 16'd6};

    applyStimulus(1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    repeat (3) nextCycle();
    reset = 1'b1;
    nextCycle();
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstLoadDone", loadDone, 0);
    checkOutput("rstReject", cfgReject, 0);
    checkOutput("rstCwrite", cwrite, 0);
    checkOutput("rstCstate", cstate, 0);
    checkOutput("rstCdata", cdata, 0);
    checkOutput("rstEvent", matchEvent, 0);
    checkOutput("rstMatchCount", matchCount, 0);
    checkOutput("rstDropCount", dropCount, 0);

    applyStimulus(1'b0, 3'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1 checkOutput("passStrobeHigh", filtRxstrobe, 1);
    applyStimulus(1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 checkOutput("passStrobeLow", filtRxstrobe, 0);
    nextCycle();

    for (int k = 0; k < 8; k++) begin
      expShadow[k] = 32'h1000_0000 + k;
      applyStimulus(1'b1, 3'(k), expShadow[k], 1'b0, 1'b0, 1'b0, 1'b0);
      nextCycle();
    end
    applyStimulus(1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (14) nextCycle();
    doCommitLoad("quietLoad");

    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (matchTable[i].gap) nextCycle();
      applyStimulus(1'b0, 3'd0, 32'd0, 1'b0, 1'b0, matchTable[i].valid, matchTable[i].match);
      nextCycle();
      checkOutput($sformatf("matchEvent%0d", i), matchEvent, matchTable[i].expEvent);
      checkOutput($sformatf("matchCount%0d", i), matchCount, matchTable[i].expCount);
    end
    applyStimulus(1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    nextCycle();

    // Strobe at S, commit at S+1, strobes at S+5 and S+10 land in WAIT_QUIET.
    applyStimulus(1'b0, 3'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1 checkOutput("fwdBeforeCommit", filtRxstrobe, 1);
    nextCycle();
    applyStimulus(1'b0, 3'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    nextCycle();
    rel = 2;
    while (rel < 40 && cwrite !== 1'b1) begin
      strobe = (rel == 5 || rel == 10);
      applyStimulus(1'b0, 3'd0, 32'd0, 1'b0, strobe, 1'b0, 1'b0);
      if (strobe) begin
        #1 checkOutput($sformatf("dropGate%0d", rel), filtRxstrobe, 0);
      end
      nextCycle();
      rel++;
    end
    checkOutput("loadStartCycle", rel, 14);
    checkOutput("loadStartIdx", cstate, 0);
    applyStimulus(1'b1, 3'd3, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rejectPulse", cfgReject, 1);
    nextCycle();
    checkOutput("rejectClear", cfgReject, 0);
    repeat (6) nextCycle();
    checkOutput("gatedLoadDone", loadDone, 1);
    nextCycle();
    checkOutput("gatedIdle", busy, 0);
    checkOutput("dropCountTwo", dropCount, 2);
    doCommitLoad("reload");

    applyStimulus(1'b0, 3'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (5) nextCycle();
    checkOutput("midLoadIdx", cstate, 4);
    reset = 1'b0;
    nextCycle();
    checkOutput("midRstCwrite", cwrite, 0);
    checkOutput("midRstBusy", busy, 0);
    checkOutput("midRstCstate", cstate, 0);
    checkOutput("midRstMatchCount", matchCount, 0);
    checkOutput("midRstDropCount", dropCount, 0);
    checkOutput("midRstEvent", matchEvent, 0);
    reset = 1'b1;
    for (int k = 0; k < 8; k++) expShadow[k] = 32'd0;
    doCommitLoad("postReset");
    applyStimulus(1'b0, 3'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1 checkOutput("postRstPass", filtRxstrobe, 1);
    nextCycle();

    // Commit and strobe held high: 22 dropped strobes per 23-cycle round, 65560 in total.
    applyStimulus(1'b0, 3'd0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (68540) nextCycle();
    applyStimulus(1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (30) nextCycle();
    checkOutput("dropSatBusy", busy, 0);
    checkOutput("dropSaturated", dropCount, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
